// File: rtl/obi_mem_pkg.sv
// Shared types and helpers for the multi-port OBI memory.
// Holds the request/response pipeline records and the channel-index width helper.
package obi_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CH_MAX_W   = 3;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [WORD_BYTES-1:0] be;
    logic [31:0]           wdata;
  } obi_req_t;

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
    logic [31:0]         rdata;
    logic                err;
  } obi_rsp_pipe_t;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_multiport_mem_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping at N; the pointer moves past the winner when advance_i is set.
module rr_arbiter
  import obi_mem_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = ch_w(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = found && (win == PW'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/obi_multiport_mem.sv
// Word-addressed shared memory serving N_CH OBI requesters through a round-robin
// arbiter with a fixed-latency response pipeline. Optional OBI_MEM_RANGE_CHECK_EN.
module obi_multiport_mem
  import obi_mem_pkg::*;
#(
  parameter int    N_CH      = 3,
  parameter int    DEPTH     = 8192,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          req_i,
  output logic [N_CH-1:0]          gnt_o,
  input  logic [N_CH*32-1:0]       addr_i,
  input  logic [N_CH-1:0]          we_i,
  input  logic [N_CH*WORD_BYTES-1:0] be_i,
  input  logic [N_CH*32-1:0]       wdata_i,
  output logic [N_CH-1:0]          rvalid_o,
  output logic [N_CH*32-1:0]       rdata_o,
  output logic [N_CH-1:0]          err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [N_CH-1:0]     arb_gnt;
  logic                xfer;
  obi_req_t            sel;
  logic [CH_MAX_W-1:0] sel_ch;
  logic [AW-1:0]       widx;
  logic [31:0]         rd_word;
  logic                oor;
  logic                mem_we;
  logic                unused_bits;

  logic [31:0]   mem_q  [DEPTH];
  obi_rsp_pipe_t pipe_q [LATENCY];
  obi_rsp_pipe_t pipe_d [LATENCY];
  obi_rsp_pipe_t last;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .advance_i (xfer),
    .gnt_o     (arb_gnt)
  );

  assign gnt_o = rst_ni ? arb_gnt : '0;
  assign xfer  = |gnt_o;

  always_comb begin
    sel    = '0;
    sel_ch = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt_o[c]) begin
        sel.addr  = addr_i[c*32 +: 32];
        sel.we    = we_i[c];
        sel.be    = be_i[c*WORD_BYTES +: WORD_BYTES];
        sel.wdata = wdata_i[c*32 +: 32];
        sel_ch    = CH_MAX_W'(c);
      end
    end
  end

  assign widx    = sel.addr[AW+1:2];
  assign rd_word = mem_q[widx];

`ifdef OBI_MEM_RANGE_CHECK_EN
  assign oor = (sel.addr >> (AW + 2)) != 32'd0;
`else
  assign oor = 1'b0;
`endif

  assign mem_we = xfer & sel.we & ~oor;

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (sel.be[b]) begin
          mem_q[widx][b*8 +: 8] <= sel.wdata[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    pipe_d[0].valid = xfer;
    pipe_d[0].ch    = sel_ch;
    pipe_d[0].rdata = (xfer && !sel.we && !oor) ? rd_word : 32'd0;
    pipe_d[0].err   = xfer & oor;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign last = pipe_q[LATENCY-1];

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (last.valid && last.ch == CH_MAX_W'(c)) begin
        rvalid_o[c]         = 1'b1;
        rdata_o[c*32 +: 32] = last.rdata;
`ifdef OBI_MEM_RANGE_CHECK_EN
        err_o[c]            = last.err;
`endif
      end
    end
  end

  // Byte offset and, without range checking, upper address bits play no part.
  assign unused_bits = ^{sel.addr[31:AW+2], sel.addr[1:0], last.err};

endmodule

// File: tb/tb_obi_multiport_mem.sv
// Self-checking bench for obi_multiport_mem: behavioural reference model plus
// directed literal checks and randomized multi-channel traffic.
module tb_obi_multiport_mem;

  localparam int N_CH  = 3;
  localparam int DEPTH = 8192;
  localparam int LAT   = 2;
`ifdef OBI_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic                 clk_i  = 1'b0;
  logic                 rst_ni = 1'b1;
  logic [N_CH-1:0]      req, gnt, we, rvalid, err;
  logic [N_CH*32-1:0]   addr, wdata, rdata;
  logic [N_CH*4-1:0]    be;

  obi_multiport_mem #(
    .N_CH(N_CH), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          ch;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [31:0] mmem [DEPTH];
  rsp_t        rq[$];
  rsp_t        mr;
  int          mptr = 0, ncyc = 0, mc, mw;
  logic        moor;
  logic        pend = 1'b0;
  int          pch;
  logic        pwe;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pbe;
  logic [N_CH-1:0]    eg, ev, ee;
  logic [N_CH*32-1:0] ed;

  always @(negedge clk_i) begin
    eg = '0; ev = '0; ee = '0; ed = '0;
    pend = 1'b0;
    if (!rst_ni) begin
      rq.delete();
      mptr = 0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        mc = (mptr + k) % N_CH;
        if (!pend && req[mc]) begin
          pend = 1'b1;
          pch  = mc;
        end
      end
      if (pend) begin
        eg[pch] = 1'b1;
        pwe     = we[pch];
        paddr   = addr[pch*32 +: 32];
        pbe     = be[pch*4 +: 4];
        pwdata  = wdata[pch*32 +: 32];
      end
      if (rq.size() > 0 && rq[0].due == ncyc) begin
        ev[rq[0].ch]          = 1'b1;
        ed[rq[0].ch*32 +: 32] = rq[0].rdata;
        ee[rq[0].ch]          = rq[0].err;
        void'(rq.pop_front());
      end
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rvalid", 32'(rvalid), 32'(ev));
    chk("err", 32'(err), 32'(ee));
    for (int k = 0; k < N_CH; k++)
      chk($sformatf("rdata%0d", k), rdata[k*32 +: 32], ed[k*32 +: 32]);
  end

  always @(posedge clk_i) begin
    if (rst_ni && pend) begin
      mw       = int'(paddr[14:2]);
      moor     = RC && (paddr >= 32'h8000);
      mr.due   = ncyc + LAT;
      mr.ch    = pch;
      mr.err   = moor;
      mr.rdata = (pwe || moor) ? 32'd0 : mmem[mw];
      if (pwe && !moor)
        for (int b = 0; b < 4; b++)
          if (pbe[b]) mmem[mw][b*8 +: 8] = pwdata[b*8 +: 8];
      rq.push_back(mr);
      mptr = (pch + 1) % N_CH;
    end
    ncyc++;
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic access(input int c, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic e,
                        output int gw, output int lat);
    req[c] = 1'b1; we[c] = w; addr[c*32 +: 32] = a; be[c*4 +: 4] = b; wdata[c*32 +: 32] = d;
    rd = '0; e = 1'b0; gw = 0; lat = 0;
    @(negedge clk_i);
    while (!gnt[c] && gw < 20) begin
      @(negedge clk_i);
      gw++;
    end
    if (!gnt[c]) begin
      checks++; errors++;
      $display("FAIL grant_timeout ch%0d: no grant within 20 cycles, required one", c);
      req[c] = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    req[c] = 1'b0;
    while (lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (rvalid[c]) break;
    end
    if (!rvalid[c]) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout ch%0d: no rvalid within 20 cycles, required one", c);
    end else begin
      rd = rdata[c*32 +: 32];
      e  = err[c];
      chk("rsp_onehot", 32'(rvalid), 32'(1) << c);
      if (w) chk("wr_rdata_zero", rd, 32'd0);
    end
    @(posedge clk_i); #1;
  endtask

  logic [31:0] rd, rd2, rd0;
  logic        e1, e2, e0;
  int          gw, lat, ng, nrv;
  int          gseq[6], rseq[6];
  int          exp_rr[6] = '{0, 1, 2, 0, 1, 2};
  logic [N_CH-1:0] g;

  initial begin
    req = '1; we = '0; addr = '0; be = '0; wdata = '0;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata0", rdata[31:0], 32'd0);
    req = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // preload
    for (int i = 0; i < 16; i++)
      access(1, 1'b1, i * 4, 4'hF, 32'hC0DE0000 + i, rd, e1, gw, lat);
    access(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, e1, gw, lat);

    // read latency
    access(0, 1'b0, 32'h100, 4'hF, 32'h0, rd, e1, gw, lat);
    chk("lat_data", rd, 32'hDEADBEEF);
    chk("lat_gnt_wait", 32'(gw), 32'd0);
    chk("lat_cycles", 32'(lat), 32'(LAT));

    // round robin from a fresh pointer
    rst_ni = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    req = '1; we = '0;
    addr = {32'h8, 32'h4, 32'h0};
    for (int i = 0; i < 6 + LAT; i++) begin
      @(negedge clk_i);
      if (i < 6) gseq[i] = oh_idx(gnt);
      if (i >= LAT) rseq[i-LAT] = oh_idx(rvalid);
      @(posedge clk_i); #1;
      if (i == 5) req = '0;
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_gnt%0d", i), 32'(gseq[i]), 32'(exp_rr[i]));
      chk($sformatf("rr_rvalid%0d", i), 32'(rseq[i]), 32'(exp_rr[i]));
    end

    // byte-enable write
    access(0, 1'b1, 32'h200, 4'hF, 32'hAABBCCDD, rd, e1, gw, lat);
    access(1, 1'b1, 32'h200, 4'b0101, 32'h11223344, rd, e1, gw, lat);
    access(2, 1'b0, 32'h200, 4'hF, 32'h0, rd, e1, gw, lat);
    chk("be_merge", rd, 32'hAA22CC44);

    // back-to-back streaming
    req[0] = 1'b1; we[0] = 1'b0; be[3:0] = 4'hF; addr[31:0] = 32'h0;
    ng = 0; nrv = 0;
    for (int i = 0; i < 8 + LAT; i++) begin
      @(negedge clk_i);
      if (i < 8 && gnt[0]) ng++;
      if (i >= LAT && rvalid[0]) begin
        nrv++;
        chk($sformatf("stream_data%0d", i - LAT), rdata[31:0], 32'hC0DE0000 + 32'(i - LAT));
      end
      @(posedge clk_i); #1;
      if (i < 7) addr[31:0] = 32'((i + 1) * 4);
      else if (i == 7) req[0] = 1'b0;
    end
    chk("stream_grants", 32'(ng), 32'd8);
    chk("stream_rvalids", 32'(nrv), 32'd8);

    // reset while a read is in flight
    req[0] = 1'b1; we[0] = 1'b0; addr[31:0] = 32'h100;
    @(negedge clk_i);
    chk("midrst_gnt", 32'(gnt), 32'h1);
    @(posedge clk_i); #1;
    req[0] = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    nrv = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (rvalid != '0) nrv++;
    end
    chk("midrst_no_rvalid", 32'(nrv), 32'd0);
    @(posedge clk_i); #1;
    access(0, 1'b0, 32'h100, 4'hF, 32'h0, rd, e1, gw, lat);
    chk("midrst_mem_kept", rd, 32'hDEADBEEF);

    // out-of-range / wrapping address
    access(0, 1'b1, 32'h8000, 4'hF, 32'h55555555, rd, e1, gw, lat);
    access(0, 1'b0, 32'h8000, 4'hF, 32'h0, rd2, e2, gw, lat);
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, rd0, e0, gw, lat);
    if (RC) begin
      chk("range_wr_err", 32'(e1), 32'd1);
      chk("range_rd_err", 32'(e2), 32'd1);
      chk("range_rd_data", rd2, 32'd0);
      chk("range_mem0", rd0, 32'hC0DE0000);
    end else begin
      chk("wrap_wr_err", 32'(e1), 32'd0);
      chk("wrap_rd_err", 32'(e2), 32'd0);
      chk("wrap_rd_data", rd2, 32'h55555555);
      chk("wrap_mem0", rd0, 32'h55555555);
    end

    // randomized traffic, checked by the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      g = gnt;
      @(posedge clk_i); #1;
      for (int c = 0; c < N_CH; c++) begin
        if (req[c] && !g[c] && $urandom_range(7) != 0) begin
          // hold pending request stable
        end else if ($urandom_range(2) == 0) begin
          req[c] = 1'b0;
        end else begin
          req[c]            = 1'b1;
          we[c]             = 1'($urandom_range(1));
          addr[c*32 +: 32]  = 32'($urandom_range(15) * 4) | 32'($urandom_range(3))
                              | (($urandom_range(7) == 0) ? 32'h8000 : 32'h0);
          be[c*4 +: 4]      = 4'($urandom);
          wdata[c*32 +: 32] = $urandom;
        end
      end
    end
    req = '0;
    repeat (LAT + 4) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
